// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor, SEG bits summed per stage.
// Ports: clk, rst (async high); in_valid/in_ready + a, b, cin, sub in;
//        out_valid/out_ready + sum, cout, ovf out. Whole-pipe stall.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // Per-stage registers. a_q/b_q carry the operands forward (skew);
    // s_q accumulates finished low segments (deskew). Bits that no later
    // stage reads are left for synthesis to prune.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    // Stage inputs: index 0 is the capture port, k>0 is stage k-1.
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] v_src;
    logic [SEG:0]      seg_sum [STAGES];

    logic en;

    assign out_valid = v_q[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    always_comb begin
        // B is inverted and the carry forced to 1 at capture for subtract.
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        c_src[0] = sub | cin;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, a_src[k][k*SEG +: SEG]}
                       + {1'b0, b_src[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_src[k]};
            a_d[k] = a_src[k];
            b_d[k] = b_src[k];
            s_d[k] = s_src[k];
            s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            c_d[k] = seg_sum[k][SEG];
            v_d[k] = v_src[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // Signed overflow: operands agree in sign but the result does not.
    assign sum  = s_q[STAGES-1];
    assign cout = c_q[STAGES-1];
    assign ovf  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
               && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, reset, streaming with
// backpressure across four (WIDTH,SEG) configurations.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv, ir, ov, ordy, co, of;
    logic [31:0] a_x, b_x;
    logic        cin_x, sub_x;
    logic [15:0] s0, s1;
    logic [31:0] s2;
    logic [7:0]  s3;
    logic [31:0] sum_x [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign sum_x[0] = {16'b0, s0};
    assign sum_x[1] = {16'b0, s1};
    assign sum_x[2] = s2;
    assign sum_x[3] = {24'b0, s3};

    pipelined_addsub #(.WIDTH(16), .SEG(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_x[15:0]), .b(b_x[15:0]), .cin(cin_x), .sub(sub_x),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s0), .cout(co[0]), .ovf(of[0]));

    pipelined_addsub #(.WIDTH(16), .SEG(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_x[15:0]), .b(b_x[15:0]), .cin(cin_x), .sub(sub_x),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]), .ovf(of[1]));

    pipelined_addsub #(.WIDTH(32), .SEG(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_x), .b(b_x), .cin(cin_x), .sub(sub_x),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s2), .cout(co[2]), .ovf(of[2]));

    pipelined_addsub #(.WIDTH(8), .SEG(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_x[7:0]), .b(b_x[7:0]), .cin(cin_x), .sub(sub_x),
        .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(s3), .cout(co[3]), .ovf(of[3]));

    int wid [4] = '{16, 16, 32, 8};
    int lat [4] = '{4, 1, 4, 8};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model(input int w,
        input logic [31:0] av, input logic [31:0] bv,
        input logic c, input logic s);
        logic [63:0] m, aa, bb, full, sm;
        logic        cy, ov_b;
        m    = (64'd1 << w) - 64'd1;
        aa   = {32'b0, av} & m;
        bb   = s ? (~{32'b0, bv} & m) : ({32'b0, bv} & m);
        full = aa + bb + {63'b0, (s ? 1'b1 : c)};
        sm   = full & m;
        cy   = full[w];
        ov_b = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
        return {ov_b, cy, sm[31:0]};
    endfunction

    function automatic logic [33:0] obs_of(input int i);
        return {of[i], co[i], sum_x[i]};
    endfunction

    task automatic run_one(input int i, input logic [31:0] av,
        input logic [31:0] bv, input logic c, input logic s,
        input logic [31:0] es, input logic ec, input logic eo,
        input string tag);
        int n;
        @(negedge clk);
        a_x = av; b_x = bv; cin_x = c; sub_x = s;
        ordy[i] = 1'b1;
        iv[i] = 1'b1;
        #1 check({tag, " in_ready"}, ir[i], 1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        iv[i] = 1'b0;
        while (!ov[i] && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, n, lat[i]);
        check({tag, " result"}, obs_of(i), {eo, ec, es});
    endtask

    task automatic stream(input int i, input int n);
        logic [33:0] exp_q [$];
        logic [33:0] hold_o;
        logic [31:0] m;
        bit          hold_v = 0;
        bit          need_new = 1;
        int          sent = 0, got = 0, cyc = 0, extra = 0;
        int          stall_at;
        m = (wid[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[i]) - 1);
        stall_at = 2 * lat[i] + 4;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (need_new) begin
                a_x = $urandom & m;
                b_x = $urandom & m;
                cin_x = 1'($urandom_range(0, 1));
                sub_x = 1'($urandom_range(0, 1));
                need_new = 0;
            end
            iv[i] = (sent < n);
            ordy[i] = (cyc >= stall_at && cyc < stall_at + 5) ? 1'b0
                    : ($urandom_range(0, 3) != 0);
            #1;
            check("stream in_ready", ir[i], !(ov[i] && !ordy[i]));
            if (hold_v)
                check("stream hold", {ov[i], obs_of(i)}, {1'b1, hold_o});
            if (ov[i] && ordy[i]) begin
                if (exp_q.size() > 0) begin
                    check("stream result", obs_of(i), exp_q.pop_front());
                    got++;
                end else begin
                    check("stream extra result", ov[i], 0);
                end
            end
            hold_v = ov[i] && !ordy[i];
            hold_o = obs_of(i);
            if (iv[i] && ir[i]) begin
                exp_q.push_back(model(wid[i], a_x, b_x, cin_x, sub_x));
                sent++;
                need_new = 1;
            end
            @(posedge clk);
        end
        iv[i] = 1'b0;
        ordy[i] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ov[i]) extra++;
        end
        check("stream count", got, n);
        check("stream leftover", exp_q.size(), 0);
        check("stream duplicates", extra, 0);
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        iv = '0;
        ordy = '1;
        a_x = '0; b_x = '0; cin_x = 1'b0; sub_x = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", ov, 0);
        check("reset sum", sum_x[0], 0);
        check("reset cout/ovf", {co[0], of[0]}, 0);
        check("reset in_ready", ir, 4'hF);
        rst = 1'b0;

        run_one(0, 32'h00FF, 32'h0001, 1'b0, 1'b0,
                32'h0100, 1'b0, 1'b0, "add 00FF+0001");
        run_one(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0,
                32'h0000, 1'b1, 1'b0, "ripple FFFF+0+1");
        run_one(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0,
                32'h8000, 1'b0, 1'b1, "ovf 7FFF+1");
        run_one(0, 32'h0005, 32'h0007, 1'b1, 1'b1,
                32'hFFFE, 1'b0, 1'b0, "sub 5-7");
        run_one(0, 32'h8000, 32'h0001, 1'b0, 1'b1,
                32'h7FFF, 1'b1, 1'b1, "sub 8000-1");
        run_one(1, 32'h0001, 32'hFFFF, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, "w16s16 1+-1");
        run_one(2, 32'h0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, "w32s8 1+-1");
        run_one(3, 32'h0001, 32'h00FF, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, "w8s1 1+-1");

        // Reset with three operations in flight and one stalled at output.
        @(negedge clk);
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        a_x = 32'h7FFF; b_x = 32'h7FFF; cin_x = 1'b0; sub_x = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre-reset out_valid", ov[0], 1);
        check("pre-reset sum", sum_x[0], 32'hFFFE);
        #1 rst = 1'b1;
        #1;
        check("mid reset out_valid", ov[0], 0);
        check("mid reset sum", sum_x[0], 0);
        check("mid reset cout/ovf", {co[0], of[0]}, 0);
        check("mid reset in_ready", ir[0], 1);
        @(negedge clk);
        rst = 1'b0;
        ordy[0] = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov[0]) stale++;
        end
        check("post reset stale", stale, 0);
        check("post reset in_ready", ir[0], 1);

        for (int i = 0; i < 4; i++) stream(i, 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
